data_packer: RTL and testbench

//  Packs a stream of narrow IN_WIDTH words into wide OUT_WIDTH words for the packed-write FIFO.

---
 rtl/data_packer_pkg.sv | 37 +++
 rtl/data_packer_if.sv | 48 ++++
 rtl/data_packer.sv | 93 +++++++++
 tb/tb_data_packer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_packer_pkg.sv
// Shared constants and helper functions for the data packer and its bus interface.
package data_packer_pkg;

  // Integer ceiling of a / b.
  function automatic int ceil_a_by_b(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Number of bits needed to encode the values 0 .. value-1.
  function automatic int c_log_2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  // Input words per packed output word.
  function automatic int ratio_of(input int out_width, input int in_width);
    return ceil_a_by_b(out_width, in_width);
  endfunction

  // Width of the lane count, which must encode 1 .. RATIO.
  function automatic int lane_w_of(input int out_width, input int in_width);
    return c_log_2(ratio_of(out_width, in_width) + 1);
  endfunction

  // Legal geometry: output is a whole multiple (at least two) of the input width.
  function automatic bit widths_ok(input int out_width, input int in_width);
    return (in_width > 0) && (out_width % in_width == 0) && (out_width / in_width >= 2);
  endfunction

endpackage

// File: rtl/data_packer_if.sv
// Bus bundle for the packer: narrow unpacked input stream and wide packed write port.
interface data_packer_if
  import data_packer_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 128
) ();

  localparam int LANE_W = lane_w_of(OUT_WIDTH, IN_WIDTH);

  logic                 s_unpacked_valid;
  logic                 s_unpacked_ready;
  logic [IN_WIDTH-1:0]  s_unpacked_data;
  logic                 s_unpacked_last;

  logic                 m_packed_write_ready;
  logic                 m_packed_write_req;
  logic [OUT_WIDTH-1:0] m_packed_write_data;
  logic [LANE_W-1:0]    m_packed_write_lanes;
  logic                 m_packed_write_last;

  // Packer side: consumes the narrow stream, produces packed writes.
  modport slave (
    input  s_unpacked_valid,
    input  s_unpacked_data,
    input  s_unpacked_last,
    input  m_packed_write_ready,
    output s_unpacked_ready,
    output m_packed_write_req,
    output m_packed_write_data,
    output m_packed_write_lanes,
    output m_packed_write_last
  );

  // Environment side: produces the narrow stream, sinks packed writes.
  modport master (
    output s_unpacked_valid,
    output s_unpacked_data,
    output s_unpacked_last,
    output m_packed_write_ready,
    input  s_unpacked_ready,
    input  m_packed_write_req,
    input  m_packed_write_data,
    input  m_packed_write_lanes,
    input  m_packed_write_last
  );

endinterface

// File: rtl/data_packer.sv
// Packs narrow input words LSB-first into wide words; a last-flagged input flushes a
// partial word zero-padded together with its lane count.
module data_packer
  import data_packer_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 128,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  data_packer_if.slave      bus,
  output logic [CNT_W-1:0]  packed_count
);

  localparam int RATIO  = ratio_of(OUT_WIDTH, IN_WIDTH);
  localparam int LANE_W = lane_w_of(OUT_WIDTH, IN_WIDTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  if (!widths_ok(OUT_WIDTH, IN_WIDTH)) begin : g_bad_widths
    $error("data_packer: OUT_WIDTH must be a multiple (>= 2) of IN_WIDTH");
  end

  logic [LANE_W-1:0]    lane_cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] merged;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic [LANE_W-1:0]    out_lanes;
  logic                 out_last;

  logic accept;
  logic complete;
  logic push;

  // A held word blocks new input only while the sink refuses it; reset also blocks input.
  assign bus.s_unpacked_ready = !reset && (!out_valid || bus.m_packed_write_ready);
  assign accept   = bus.s_unpacked_valid && bus.s_unpacked_ready;
  assign complete = accept && ((lane_cnt == LAST_LANE) || bus.s_unpacked_last);
  assign push     = out_valid && bus.m_packed_write_ready;

  // Lane-insert mux: the current lane takes the input word, filled lanes keep the
  // accumulator, lanes above the current one are forced to zero (padding on flush).
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    localparam logic [LANE_W-1:0] LANE = LANE_W'(g);
    assign merged[g*IN_WIDTH +: IN_WIDTH] =
      (lane_cnt == LANE) ? bus.s_unpacked_data :
      (lane_cnt >  LANE) ? acc[g*IN_WIDTH +: IN_WIDTH] :
                           '0;
  end

  // Accumulate lanes, close words on the last lane or a last flag, and count pushes.
  // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cnt     <= '0;
      acc          <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_lanes    <= '0;
      out_last     <= 1'b0;
      packed_count <= '0;
    end else begin
      if (complete) begin
        out_data  <= merged;
        out_lanes <= lane_cnt + LANE_W'(1);
        out_last  <= bus.s_unpacked_last;
        acc       <= '0;
        lane_cnt  <= '0;
      end else if (accept) begin
        acc       <= merged;
        lane_cnt  <= lane_cnt + LANE_W'(1);
      end

      // A word completing in the same cycle as a drain replaces the drained one.
      if (complete) begin
        out_valid <= 1'b1;
      end else if (push) begin
        out_valid <= 1'b0;
      end

      if (push) begin
        packed_count <= packed_count + CNT_W'(1);
      end
    end
  end

  assign bus.m_packed_write_req   = push;
  assign bus.m_packed_write_data  = out_data;
  assign bus.m_packed_write_lanes = out_lanes;
  assign bus.m_packed_write_last  = out_last;

endmodule

// File: tb/tb_data_packer.sv
// Scoreboard bench for data_packer: a transfer-level reference model predicts packed
// words at input-accept time; an independent monitor compares every push.
module tb_data_packer;

  localparam int IN_WIDTH  = 64;
  localparam int OUT_WIDTH = 128;
  localparam int CNT_W     = 4;
  localparam int RATIO     = OUT_WIDTH / IN_WIDTH;

  typedef struct {
    logic [OUT_WIDTH-1:0] data;
    int                   lanes;
    logic                 last;
  } word_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] packed_count;

  data_packer_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  data_packer #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .packed_count(packed_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  word_t               exp_q[$];
  word_t               got_q[$];
  logic [IN_WIDTH-1:0] cur[$];
  int                  exp_cnt      = 0;
  int                  push_total   = 0;
  int                  stall_cycles = 0;
  int                  bp_mode      = 1;   // 0: sink full, 1: sink ready, 2: random

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference model: gather accepted inputs of the current word; close it after RATIO
  // inputs or on a last flag, placing input i at bit offset i*IN_WIDTH.
  task automatic model_accept(input logic [IN_WIDTH-1:0] d, input logic l);
    word_t w;
    cur.push_back(d);
    if (l || cur.size() == RATIO) begin
      w.data = '0;
      foreach (cur[i]) w.data = w.data | (OUT_WIDTH'(cur[i]) << (i * IN_WIDTH));
      w.lanes = cur.size();
      w.last  = l;
      exp_q.push_back(w);
      cur.delete();
    end
  endtask

  // Sink model: drives write-ready according to bp_mode.
  initial begin
    bus.m_packed_write_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       bus.m_packed_write_ready = 1'b0;
        1:       bus.m_packed_write_ready = 1'b1;
        default: bus.m_packed_write_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: every push is compared against the oldest predicted word and count.
  always @(negedge clk) begin
    word_t got;
    word_t e;
    if (reset) begin
      exp_cnt = 0;
    end else if (bus.m_packed_write_req) begin
      got.data  = bus.m_packed_write_data;
      got.lanes = int'(bus.m_packed_write_lanes);
      got.last  = bus.m_packed_write_last;
      got_q.push_back(got);
      push_total++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_push: got data 0x%0h, expected no push", got.data);
      end else begin
        e = exp_q.pop_front();
        check("push_data",  128'(got.data),  128'(e.data));
        check("push_lanes", 128'(got.lanes), 128'(e.lanes));
        check("push_last",  128'(got.last),  128'(e.last));
      end
      check("push_count", 128'(packed_count), 128'(exp_cnt));
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    end
  end

  // Offer one input word and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [IN_WIDTH-1:0] d, input logic l);
    int waited;
    waited = 0;
    bus.s_unpacked_valid = 1'b1;
    bus.s_unpacked_data  = d;
    bus.s_unpacked_last  = l;
    forever begin
      @(negedge clk);
      if (bus.s_unpacked_ready) begin
        model_accept(d, l);
        break;
      end
      stall_cycles++;
      waited++;
      if (waited > 200) begin
        fail("accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.s_unpacked_valid = 1'b0;
    bus.s_unpacked_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    idle(2);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    exp_q.delete();
    cur.delete();
    repeat (2) begin
      @(negedge clk);
      check("ready_in_reset", 128'(bus.s_unpacked_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_unpacked_valid = 1'b0;
    bus.s_unpacked_data  = '0;
    bus.s_unpacked_last  = 1'b0;

    // Reset state
    reset_dut();
    @(negedge clk);
    check("rst_req",   128'(bus.m_packed_write_req),   128'(0));
    check("rst_data",  128'(bus.m_packed_write_data),  128'(0));
    check("rst_lanes", 128'(bus.m_packed_write_lanes), 128'(0));
    check("rst_last",  128'(bus.m_packed_write_last),  128'(0));
    check("rst_count", 128'(packed_count),             128'(0));
    check("rst_ready", 128'(bus.s_unpacked_ready),     128'(1));
    idle(1);

    // Four inputs, sink ready: two full words
    got_q.delete();
    for (int i = 1; i <= 4; i++) send(64'(i), 1'b0);
    wait_drain();
    check("t1_pushes", 128'(got_q.size()), 128'(2));
    check("t1_word0",  128'(got_q[0].data), {64'h2, 64'h1});
    check("t1_word1",  128'(got_q[1].data), {64'h4, 64'h3});
    check("t1_lanes",  128'(got_q[1].lanes), 128'(2));
    check("t1_last",   128'(got_q[0].last), 128'(0));
    @(negedge clk);
    check("t1_count",  128'(packed_count), 128'(2));
    idle(1);

    // Last on the first lane of the second word: zero-padded single-lane flush
    got_q.delete();
    send(64'hA, 1'b0);
    send(64'hB, 1'b0);
    send(64'hC, 1'b1);
    wait_drain();
    check("t2_word0", 128'(got_q[0].data), {64'hB, 64'hA});
    check("t2_lanes0", 128'(got_q[0].lanes), 128'(2));
    check("t2_last0", 128'(got_q[0].last), 128'(0));
    check("t2_word1", 128'(got_q[1].data), {64'h0, 64'hC});
    check("t2_lanes1", 128'(got_q[1].lanes), 128'(1));
    check("t2_last1", 128'(got_q[1].last), 128'(1));

    // Backpressure: a pending word holds and blocks input while the sink is full
    bp_mode = 0;
    idle(2);
    got_q.delete();
    send(64'h11, 1'b0);
    send(64'h22, 1'b0);
    bus.s_unpacked_valid = 1'b1;
    bus.s_unpacked_data  = 64'h33;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_req",   128'(bus.m_packed_write_req),   128'(0));
      check("stall_ready", 128'(bus.s_unpacked_ready),     128'(0));
      check("stall_data",  128'(bus.m_packed_write_data),  {64'h22, 64'h11});
      check("stall_lanes", 128'(bus.m_packed_write_lanes), 128'(2));
    end
    idle(1);
    bus.s_unpacked_valid = 1'b0;
    bp_mode = 1;
    idle(6);
    check("stall_release_pushes", 128'(got_q.size()), 128'(1));
    wait_drain();

    // Continuous stream at full rate: no stalls, LSB-first order preserved
    stall_cycles = 0;
    got_q.delete();
    for (int i = 0; i < 64; i++) send(64'(256 + i), 1'b0);
    wait_drain();
    check("stream_stalls", 128'(stall_cycles), 128'(0));
    check("stream_pushes", 128'(got_q.size()), 128'(32));
    for (int k = 0; k < 32; k++)
      check("stream_order", 128'(got_q[k].data), {64'(256 + 2*k + 1), 64'(256 + 2*k)});

    // Reset after one lane: partial word discarded, fresh word afterwards
    got_q.delete();
    send(64'h55, 1'b0);
    reset_dut();
    idle(4);
    check("midrst_pushes", 128'(got_q.size()), 128'(0));
    check("midrst_count",  128'(packed_count), 128'(0));
    send(64'h66, 1'b0);
    send(64'h77, 1'b0);
    wait_drain();
    check("midrst_word",  128'(got_q[0].data), {64'h77, 64'h66});
    check("midrst_lanes", 128'(got_q[0].lanes), 128'(2));

    // Counter wrap: 2^CNT_W + 1 pushes from reset leaves the count at 1
    reset_dut();
    idle(1);
    got_q.delete();
    for (int i = 0; i < 2 * ((1 << CNT_W) + 1); i++) send({$urandom, $urandom}, 1'b0);
    wait_drain();
    check("wrap_pushes", 128'(got_q.size()), 128'((1 << CNT_W) + 1));
    @(negedge clk);
    check("wrap_count", 128'(packed_count), 128'(1));
    idle(1);

    // Randomized traffic with random last flags, idle gaps and sink backpressure
    bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send({$urandom, $urandom}, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    bp_mode = 1;
    wait_drain();
    check("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
